video_tile_compositor: RTL and testbench

- Read-side compositor for NUM_CH grayscale frame buffers, all held in dual-port BRAM.
- Takes raster timing from video_sig_gen and drives one read address per channel.
- Composites the returned pixels into a delay-matched RGB stream, with matching syncs, for the tmds_encoders.
- Generalises the fixed two-tile side-by-side path to N tiles, plus a 2x single-channel view and an |ch0-ch1| stereo-difference view.

---
 rtl/video_tile_compositor_pkg.sv | 22 ++
 rtl/video_tile_compositor_if.sv | 34 +++
 rtl/video_tile_compositor_pipe_delay.sv | 24 ++
 rtl/video_tile_compositor.sv | 155 +++++++++++++++
 tb/tb_video_tile_compositor.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/video_tile_compositor_pkg.sv
// Shared types for the tile compositor: display modes, default background
// colour and the per-pixel tag that travels alongside the BRAM read.
package video_comp_pkg;

    typedef enum logic [1:0] {
        MODE_TILE   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_DIFF   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam logic [23:0] BG_RGB_DEFAULT = 24'h9C27B0;

    // diff marks a |ch0-ch1| pixel so the last stage need not know the mode
    typedef struct packed {
        logic       valid_region;
        logic       ad;
        logic       diff;
        logic [1:0] src_sel;
    } tag_t;

endpackage

// File: rtl/video_tile_compositor_if.sv
// Raster-in / BRAM / video-out bundle around the compositor.
// master is the compositor side, slave is the raster source / BRAM / encoder side.
interface video_tile_compositor_if #(
    parameter int NUM_CH = 2,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16
);
    logic [10:0]              hcount_in;
    logic [9:0]               vcount_in;
    logic                     hs_in;
    logic                     vs_in;
    logic                     ad_in;
    logic                     nf_in;
    logic [1:0]               mode_in;
    logic [1:0]               sel_in;
    logic [NUM_CH*ADDR_W-1:0] addr_out;
    logic [NUM_CH*PIX_W-1:0]  pix_in;
    logic [7:0]               red_out;
    logic [7:0]               green_out;
    logic [7:0]               blue_out;
    logic                     hs_out;
    logic                     vs_out;
    logic                     ad_out;

    modport master (
        input  hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in, mode_in, sel_in, pix_in,
        output addr_out, red_out, green_out, blue_out, hs_out, vs_out, ad_out
    );

    modport slave (
        output hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in, mode_in, sel_in, pix_in,
        input  addr_out, red_out, green_out, blue_out, hs_out, vs_out, ad_out
    );
endinterface

// File: rtl/video_tile_compositor_pipe_delay.sv
// Fixed-depth shift register with async active-low clear; used for the sync
// delays and for aligning pixel tags with BRAM read data.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/video_tile_compositor.sv
// Read-side compositor: turns raster position into per-channel BRAM addresses,
// then merges the returned grayscale pixels into a sync-aligned RGB stream.
module video_tile_compositor
    import video_comp_pkg::*;
#(
    parameter int          NUM_CH = 2,
    parameter int          TILE_W = 320,
    parameter int          TILE_H = 180,
    parameter int          PIX_W  = 8,
    parameter int          RD_LAT = 2,
    parameter int          ADDR_W = $clog2(TILE_W*TILE_H),
    parameter logic [23:0] BG_RGB = BG_RGB_DEFAULT
) (
    input logic                   clk_in,
    input logic                   rst_in,
    video_tile_compositor_if.master vif
);
    localparam int AW1 = ADDR_W + 1;
    localparam int CH1 = (NUM_CH > 1) ? 1 : 0;

    mode_e                           mode_q;
    logic [1:0]                      sel_q;
    int                              h_i, v_i;
    logic [AW1-1:0]                  h_w, v_w, tile_row, single_addr;
    logic                            in_rows, in_tile0, in_single;
    logic [NUM_CH-1:0][ADDR_W-1:0]   addr_nxt, addr_q;
    tag_t                            tag_nxt, tag_q, tag_al;
    logic [NUM_CH-1:0][PIX_W-1:0]    pix;
    logic [PIX_W:0]                  diff_full;
    logic [PIX_W-1:0]                sel_pix, diff_pix, gray;
    logic [7:0]                      g8;
    logic [23:0]                     rgb_q;
    logic [2:0]                      sync_d;

    // Mode/sel only move on the new-frame pulse so a frame is never split.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mode_q <= MODE_TILE;
            sel_q  <= '0;
        end else if (vif.nf_in) begin
            mode_q <= mode_e'(vif.mode_in);
            sel_q  <= vif.sel_in;
        end
    end

    assign h_i         = int'(vif.hcount_in);
    assign v_i         = int'(vif.vcount_in);
    assign h_w         = AW1'(vif.hcount_in);
    assign v_w         = AW1'(vif.vcount_in);
    assign tile_row    = v_w * AW1'(TILE_W);
    assign single_addr = (h_w >> 1) + (v_w >> 1) * AW1'(TILE_W);
    assign in_rows     = v_i < TILE_H;
    assign in_tile0    = in_rows && (h_i < TILE_W);
    assign in_single   = (h_i < 2*TILE_W) && (v_i < 2*TILE_H);

    always_comb begin
        addr_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            case (mode_q)
                MODE_TILE:
                    if (in_rows && h_i >= k*TILE_W && h_i < (k+1)*TILE_W)
                        addr_nxt[k] = ADDR_W'(h_w - AW1'(k*TILE_W) + tile_row);
                MODE_SINGLE:
                    if (in_single && sel_q == 2'(k))
                        addr_nxt[k] = ADDR_W'(single_addr);
                MODE_DIFF:
                    if (NUM_CH >= 2 && k < 2 && in_tile0)
                        addr_nxt[k] = ADDR_W'(h_w + tile_row);
                default: ;
            endcase
        end
    end

    always_comb begin
        tag_nxt    = '0;
        tag_nxt.ad = vif.ad_in;
        case (mode_q)
            MODE_TILE:
                for (int k = 0; k < NUM_CH; k++) begin
                    if (in_rows && h_i >= k*TILE_W && h_i < (k+1)*TILE_W) begin
                        tag_nxt.valid_region = 1'b1;
                        tag_nxt.src_sel      = 2'(k);
                    end
                end
            MODE_SINGLE:
                if (in_single && int'(sel_q) < NUM_CH) begin
                    tag_nxt.valid_region = 1'b1;
                    tag_nxt.src_sel      = sel_q;
                end
            MODE_DIFF:
                if (NUM_CH >= 2 && in_tile0) begin
                    tag_nxt.valid_region = 1'b1;
                    tag_nxt.diff         = 1'b1;
                end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q <= '0;
            tag_q  <= '0;
        end else begin
            addr_q <= addr_nxt;
            tag_q  <= tag_nxt;
        end
    end

    pipe_delay #(.WIDTH($bits(tag_t)), .DEPTH(RD_LAT)) u_tag_dly (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .din    (tag_q),
        .dout   (tag_al)
    );

    pipe_delay #(.WIDTH(3), .DEPTH(RD_LAT + 2)) u_sync_dly (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .din    ({vif.hs_in, vif.vs_in, vif.ad_in}),
        .dout   (sync_d)
    );

    assign pix = vif.pix_in;

    always_comb begin
        sel_pix = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (tag_al.src_sel == 2'(k)) sel_pix = pix[k];
        diff_full = {1'b0, pix[0]} - {1'b0, pix[CH1]};
        diff_pix  = diff_full[PIX_W] ? PIX_W'(-diff_full) : diff_full[PIX_W-1:0];
        gray      = tag_al.diff ? diff_pix : sel_pix;
    end

    // Narrow pixels are left-justified into the 8-bit colour channel.
    if (PIX_W >= 8) begin : g_wide
        assign g8 = gray[PIX_W-1 -: 8];
    end else begin : g_narrow
        assign g8 = {gray, {(8-PIX_W){1'b0}}};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                 rgb_q <= '0;
        else if (!tag_al.ad)         rgb_q <= '0;
        else if (tag_al.valid_region) rgb_q <= {g8, g8, g8};
        else                         rgb_q <= BG_RGB;
    end

    assign vif.addr_out  = addr_q;
    assign vif.red_out   = rgb_q[23:16];
    assign vif.green_out = rgb_q[15:8];
    assign vif.blue_out  = rgb_q[7:0];
    assign vif.hs_out    = sync_d[2];
    assign vif.vs_out    = sync_d[1];
    assign vif.ad_out    = sync_d[0];
endmodule

// File: tb/tb_video_tile_compositor.sv
// Drives two compositor builds (2ch/RD_LAT=2 and 4ch/RD_LAT=3) from one random
// raster-point stream and checks both against a per-pixel reference model.
module tb_video_tile_compositor;
    import video_comp_pkg::*;

    localparam int TW = 320, TH = 180, AW = 16, MAXC = 20000;
    localparam int LAT_A = 4, LAT_B = 5;

    typedef struct {
        int h; int v; bit hs; bit vs; bit ad;
        int mode; int sel; int pat; int da; int db; bit rstn;
    } rec_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    video_tile_compositor_if #(.NUM_CH(2), .PIX_W(8), .ADDR_W(AW)) ifa ();
    video_tile_compositor_if #(.NUM_CH(4), .PIX_W(8), .ADDR_W(AW)) ifb ();

    video_tile_compositor #(.NUM_CH(2), .RD_LAT(2)) dut_a (.clk_in(clk_in), .rst_in(rst_in), .vif(ifa));
    video_tile_compositor #(.NUM_CH(4), .RD_LAT(3)) dut_b (.clk_in(clk_in), .rst_in(rst_in), .vif(ifb));

    rec_t rec [0:MAXC-1];
    int   cyc = 0, tests = 0, fails = 0;
    int   sh_mode = 0, sh_sel = 0;
    int   cur_pat = 0, cur_da = 0, cur_db = 0;

    // Frame-buffer contents as a pure function of pattern, channel and address.
    function automatic int mem(int pat, int da, int db, int ch, int a);
        case (pat)
            0:       return ((a & 255) ^ ((a >> 8) & 255) ^ (ch * 91)) & 255;
            1:       return (ch + 1) * 17;
            default: return (ch == 0) ? da : (ch == 1) ? db : 0;
        endcase
    endfunction

    function automatic int m_addr(int nch, rec_t r, int ch);
        if (ch >= nch) return 0;
        case (r.mode)
            0: if (r.v < TH && r.h >= ch*TW && r.h < (ch+1)*TW) return (r.h - ch*TW) + r.v*TW;
            1: if (ch == r.sel && r.h < 2*TW && r.v < 2*TH) return r.h/2 + (r.v/2)*TW;
            2: if (nch >= 2 && ch < 2 && r.h < TW && r.v < TH) return r.h + r.v*TW;
            default: ;
        endcase
        return 0;
    endfunction

    function automatic logic [23:0] m_rgb(int nch, rec_t r);
        int g, a, d, c;
        g = -1;
        if (!r.ad) return 24'h0;
        case (r.mode)
            0: if (r.v < TH && r.h < nch*TW) begin
                c = r.h / TW;
                g = mem(r.pat, r.da, r.db, c, m_addr(nch, r, c));
            end
            1: if (r.sel < nch && r.h < 2*TW && r.v < 2*TH)
                g = mem(r.pat, r.da, r.db, r.sel, m_addr(nch, r, r.sel));
            2: if (nch >= 2 && r.h < TW && r.v < TH) begin
                a = m_addr(nch, r, 0);
                d = mem(r.pat, r.da, r.db, 0, a) - mem(r.pat, r.da, r.db, 1, a);
                g = (d < 0) ? -d : d;
            end
            default: ;
        endcase
        return (g < 0) ? 24'h9C27B0 : {3{8'(g)}};
    endfunction

    function automatic logic [63:0] exp_addr(int nch, int k);
        logic [63:0] e;
        e = '0;
        if (rec[k-1].rstn && rec[k].rstn)
            for (int c = 0; c < nch; c++) e[c*AW +: AW] = AW'(m_addr(nch, rec[k-1], c));
        return e;
    endfunction

    function automatic logic [63:0] exp_vid(int nch, int lat, int k);
        rec_t r;
        for (int j = k - lat; j <= k; j++) if (!rec[j].rstn) return 64'h0;
        r = rec[k-lat];
        return 64'({m_rgb(nch, r), r.hs, r.vs, r.ad});
    endfunction

    function automatic rec_t mk(int h, int v, int md, int sl, int pat, int da, int db);
        rec_t r;
        r = '{h:h, v:v, hs:1'b0, vs:1'b0, ad:1'b1, mode:md, sel:sl, pat:pat, da:da, db:db, rstn:1'b1};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    // BRAM models: registered reads with each build's latency.
    logic [7:0] bra [0:1][0:1];
    logic [7:0] brb [0:2][0:3];
    always @(posedge clk_in) begin
        for (int c = 0; c < 2; c++) begin
            bra[1][c] <= bra[0][c];
            bra[0][c] <= 8'(mem(cur_pat, cur_da, cur_db, c, int'(ifa.addr_out[c*AW +: AW])));
        end
        for (int c = 0; c < 4; c++) begin
            brb[2][c] <= brb[1][c];
            brb[1][c] <= brb[0][c];
            brb[0][c] <= 8'(mem(cur_pat, cur_da, cur_db, c, int'(ifb.addr_out[c*AW +: AW])));
        end
    end
    always_comb begin
        ifa.pix_in = '0;
        ifb.pix_in = '0;
        for (int c = 0; c < 2; c++) ifa.pix_in[c*8 +: 8] = bra[1][c];
        for (int c = 0; c < 4; c++) ifb.pix_in[c*8 +: 8] = brb[2][c];
    end

    always @(negedge clk_in) begin
        if (cyc > 6) begin
            chk("addr_a", 64'(ifa.addr_out), exp_addr(2, cyc));
            chk("addr_b", 64'(ifb.addr_out), exp_addr(4, cyc));
            chk("vid_a", 64'({ifa.red_out, ifa.green_out, ifa.blue_out, ifa.hs_out, ifa.vs_out, ifa.ad_out}),
                exp_vid(2, LAT_A, cyc));
            chk("vid_b", 64'({ifb.red_out, ifb.green_out, ifb.blue_out, ifb.hs_out, ifb.vs_out, ifb.ad_out}),
                exp_vid(4, LAT_B, cyc));
        end
    end

    task automatic step(input int h, input int v, input bit ad, input bit nf,
                        input int md, input int sl, input bit rstn);
        bit hs, vs;
        @(posedge clk_in);
        #1;
        hs = 1'($urandom);
        vs = 1'($urandom);
        cyc++;
        rst_in = rstn;
        ifa.hcount_in = 11'(h); ifb.hcount_in = 11'(h);
        ifa.vcount_in = 10'(v); ifb.vcount_in = 10'(v);
        ifa.hs_in = hs;         ifb.hs_in = hs;
        ifa.vs_in = vs;         ifb.vs_in = vs;
        ifa.ad_in = ad;         ifb.ad_in = ad;
        ifa.nf_in = nf;         ifb.nf_in = nf;
        ifa.mode_in = 2'(md);   ifb.mode_in = 2'(md);
        ifa.sel_in = 2'(sl);    ifb.sel_in = 2'(sl);
        if (!rstn) begin sh_mode = 0; sh_sel = 0; end
        rec[cyc] = '{h:h, v:v, hs:hs, vs:vs, ad:ad, mode:sh_mode, sel:sh_sel,
                     pat:cur_pat, da:cur_da, db:cur_db, rstn:rstn};
        if (rstn && nf) begin sh_mode = md; sh_sel = sl; end
    endtask

    // Non-frame cycles carry random mode/sel requests that must be ignored.
    task automatic px(input int h, input int v, input bit ad);
        step(h, v, ad, 1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
    endtask

    task automatic newframe(input int md, input int sl);
        step(0, 720, 1'b0, 1'b1, md, sl, 1'b1);
    endtask

    task automatic flush();
        repeat (8) px(2000, 1000, 1'b0);
    endtask

    task automatic rnd(input int n, input int hmax, input int vmax);
        repeat (n) px(int'($urandom_range(0, hmax)), int'($urandom_range(0, vmax)), ($urandom % 8) != 0);
    endtask

    int hl [] = '{0, 1, 2, 3, 317, 318, 319, 320, 321, 322, 637, 638, 639, 640, 641,
                  957, 958, 959, 960, 961, 1277, 1278, 1279, 1280, 1281, 1600};
    int vl [] = '{0, 1, 178, 179, 180, 181};

    initial begin
        rec[0] = '{h:0, v:0, hs:1'b0, vs:1'b0, ad:1'b0, mode:0, sel:0, pat:0, da:0, db:0, rstn:1'b0};

        chk("pin_addr_319_179", 64'(m_addr(2, mk(319, 179, 0, 0, 0, 0, 0), 0)), 64'd57599);
        chk("pin_single_2_2",   64'(m_addr(2, mk(2, 2, 1, 1, 0, 0, 0), 1)), 64'd321);
        chk("pin_single_3_3",   64'(m_addr(2, mk(3, 3, 1, 1, 0, 0, 0), 1)), 64'd321);
        chk("pin_single_unused", 64'(m_addr(2, mk(3, 3, 1, 1, 0, 0, 0), 0)), 64'd0);
        chk("pin_tile1_px",     64'(m_rgb(2, mk(320, 0, 0, 0, 0, 0, 0))), 64'h5B5B5B);
        chk("pin_bg_640",       64'(m_rgb(2, mk(640, 0, 0, 0, 0, 0, 0))), 64'h9C27B0);
        chk("pin_diff",         64'(m_rgb(2, mk(5, 5, 2, 0, 2, 16, 240))), 64'hE0E0E0);
        chk("pin_diff_swap",    64'(m_rgb(2, mk(5, 5, 2, 0, 2, 240, 16))), 64'hE0E0E0);
        chk("pin_diff_bg",      64'(m_rgb(2, mk(330, 10, 2, 0, 2, 16, 240))), 64'h9C27B0);
        chk("pin_4ch_tile3",    64'(m_rgb(4, mk(960, 0, 0, 0, 1, 0, 0))), 64'h444444);
        chk("pin_sel3_bg",      64'(m_rgb(2, mk(10, 10, 1, 3, 0, 0, 0))), 64'h9C27B0);

        repeat (4) step(int'($urandom_range(0, 1300)), int'($urandom_range(0, 400)), 1'b1, 1'b0, 1, 1, 1'b0);

        // TILE mode straight out of reset, boundary scan then random points
        foreach (vl[i]) foreach (hl[j]) px(hl[j], vl[i], 1'b1);
        rnd(1500, 1400, 400);
        for (int h = 100; h < 160; h++)
            step(h, 20, 1'b1, 1'b0, 1, 1, !(h >= 120 && h <= 122));

        newframe(1, 1);
        px(2, 2, 1'b1); px(3, 3, 1'b1); px(640, 0, 1'b1); px(639, 359, 1'b1);
        px(640, 359, 1'b1); px(639, 360, 1'b1); px(0, 0, 1'b1);
        rnd(1000, 800, 500);
        newframe(1, 3); rnd(300, 800, 500);
        newframe(1, 2); rnd(300, 800, 500);

        flush(); cur_pat = 2; cur_da = 'h10; cur_db = 'hF0;
        newframe(2, 0);
        px(5, 5, 1'b1); px(330, 10, 1'b1); px(319, 179, 1'b1); px(320, 179, 1'b1); px(319, 180, 1'b1);
        rnd(400, 400, 250);
        flush(); cur_da = 'hF0; cur_db = 'h10; rnd(300, 400, 250);
        flush(); cur_da = int'($urandom_range(0, 255)); cur_db = int'($urandom_range(0, 255)); rnd(300, 400, 250);

        flush(); cur_pat = 0;
        newframe(0, 0); rnd(200, 700, 250);
        newframe(1, 0); rnd(200, 700, 400);
        newframe(3, 0); rnd(200, 1300, 400);

        flush(); cur_pat = 1;
        newframe(0, 0);
        for (int h = 0; h < 1300; h += 7) px(h, 0, 1'b1);
        for (int h = 0; h < 1300; h += 11) px(h, 179, 1'b1);
        rnd(300, 1400, 300);

        repeat (6) begin
            flush(); cur_pat = int'($urandom_range(0, 2));
            cur_da = int'($urandom_range(0, 255)); cur_db = int'($urandom_range(0, 255));
            newframe(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            rnd(300, 1400, 400);
        end

        flush();
        repeat (4) px(0, 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
